// File: rtl/sift_kp_collector.sv
// sift_kp_collector: tags keypoints from the SIFT local-extreme stream with
// octave/row/col and queues them in a first-word-fall-through FIFO whose
// head is presented on a registered valid/ready port.
module sift_kp_collector #(
   parameter int unsigned IMG_W = 512,
   parameter int unsigned IMG_H = 512,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kp_en,
   input  logic              kp_flag,
   input  logic [7:0]        kp_max,
   input  logic [7:0]        kp_min,
   input  logic              complete1,
   input  logic              complete2,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [2*CW+16:0]  m_data,
   output logic              octave,
   output logic [15:0]       kp_count,
   output logic [15:0]       drop_cnt,
   output logic              overflow,
   output logic              frame_err,
   output logic              done
);

   localparam int unsigned DW = 2 * CW + 17;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned NW = AW + 1;

   localparam logic [CW-1:0] COL_LAST0 = CW'(IMG_W - 1);
   localparam logic [CW-1:0] ROW_LAST0 = CW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LAST1 = CW'(IMG_W / 2 - 1);
   localparam logic [CW-1:0] ROW_LAST1 = CW'(IMG_H / 2 - 1);

   typedef enum logic [1:0] {
      SCAN0 = 2'd0,
      SCAN1 = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            c1_q, c2_q;
   logic            c1_rise, c2_rise;

   logic [CW-1:0]   col_q, col_d;
   logic [CW-1:0]   row_q, row_d;
   logic            done_oct_q, done_oct_d;
   logic [CW-1:0]   col_last, row_last;

   logic            scanning;
   logic            pos_ok;
   logic            push;
   logic            pop;
   logic            wr_en;
   logic            drop;
   logic            full;
   logic            bad_strobe;
   logic [DW-1:0]   entry;

   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [NW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   head_d;

   // Marker edge detection against the previous-cycle level.
   assign c1_rise = complete1 & ~c1_q;
   assign c2_rise = complete2 & ~c2_q;

   // Strobe qualification and FIFO handshake terms.
   always_comb begin
      scanning   = (state_q == SCAN0) || (state_q == SCAN1);
      pos_ok     = kp_en & scanning & ~done_oct_q;
      bad_strobe = kp_en & (~scanning | done_oct_q);
      push       = pos_ok & kp_flag;
      pop        = m_valid & m_ready;
      full       = (cnt_q == NW'(DEPTH));
      wr_en      = push & (~full | pop);
      drop       = push & full & ~pop;
      entry      = {octave, row_q, col_q, kp_max, kp_min};
   end

   // Next-state logic for the scan / drain sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN0: begin
            if (c2_rise) begin
               state_d = DRAIN;
            end else if (c1_rise) begin
               state_d = SCAN1;
            end
         end
         SCAN1: begin
            if (c2_rise) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = SCAN0;
         end
      endcase
   end

   // Raster position tracking; the octave-0 -> octave-1 switch restarts at origin.
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      done_oct_d = done_oct_q;
      col_last   = octave ? COL_LAST1 : COL_LAST0;
      row_last   = octave ? ROW_LAST1 : ROW_LAST0;
      if ((state_q == SCAN0) && (state_d == SCAN1)) begin
         col_d      = '0;
         row_d      = '0;
         done_oct_d = 1'b0;
      end else if (pos_ok) begin
         if (col_q == col_last) begin
            if (row_q == row_last) begin
               done_oct_d = 1'b1;
            end else begin
               col_d = '0;
               row_d = row_q + CW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // FIFO pointer/occupancy update and look-ahead of the next head word.
   always_comb begin
      rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      cnt_d    = cnt_q;
      case ({wr_en, pop})
         2'b10:   cnt_d = cnt_q + NW'(1);
         2'b01:   cnt_d = cnt_q - NW'(1);
         default: cnt_d = cnt_q;
      endcase
      // A word written into the slot that becomes the head bypasses the array.
      if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
         head_d = entry;
      end else begin
         head_d = mem[rd_ptr_d];
      end
   end

   // FIFO storage array; contents are don't-care while unoccupied.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= entry;
      end
   end

   // Sequencer, position counters, FIFO control and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SCAN0;
         c1_q       <= 1'b0;
         c2_q       <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         done_oct_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         octave     <= 1'b0;
         kp_count   <= '0;
         drop_cnt   <= '0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         c1_q       <= complete1;
         c2_q       <= complete2;
         col_q      <= col_d;
         row_q      <= row_d;
         done_oct_q <= done_oct_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         m_valid    <= (cnt_d != '0);
         m_data     <= (cnt_d != '0) ? head_d : '0;
         octave     <= (state_d != SCAN0);
         done       <= (state_d == DONE);
         if (wr_en && (kp_count != 16'hFFFF)) begin
            kp_count <= kp_count + 16'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
               drop_cnt <= drop_cnt + 16'd1;
            end
         end
         if (bad_strobe) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sift_kp_collector.sv
// tb_sift_kp_collector: directed table + hand sequences + randomized run of
// sift_kp_collector, every cycle checked against a queue-based reference model.
module tb_sift_kp_collector;

   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int DW    = 2 * CW + 17;

   logic          clk;
   logic          rst;
   logic          kp_en;
   logic          kp_flag;
   logic [7:0]    kp_max;
   logic [7:0]    kp_min;
   logic          complete1;
   logic          complete2;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          octave;
   logic [15:0]   kp_count;
   logic [15:0]   drop_cnt;
   logic          overflow;
   logic          frame_err;
   logic          done;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int            md_phase;   // 0 scan oct0, 1 scan oct1, 2 drain, 3 done
   int            md_n;       // accepted positions in current octave
   bit            md_oct;
   logic [DW-1:0] md_q[$];
   int            md_kcnt;
   int            md_dcnt;
   bit            md_ovf;
   bit            md_ferr;
   bit            md_done;
   bit            md_c1p;
   bit            md_c2p;

   sift_kp_collector #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH(DEPTH), .CW(CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .kp_en     (kp_en),
      .kp_flag   (kp_flag),
      .kp_max    (kp_max),
      .kp_min    (kp_min),
      .complete1 (complete1),
      .complete2 (complete2),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .octave    (octave),
      .kp_count  (kp_count),
      .drop_cnt  (drop_cnt),
      .overflow  (overflow),
      .frame_err (frame_err),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      int w;
      int h;
      bit was_empty;
      bit pop;
      bit c1r;
      bit c2r;
      logic [DW-1:0] e;
      if (rst) begin
         md_phase = 0; md_n = 0; md_oct = 0; md_q.delete();
         md_kcnt = 0; md_dcnt = 0; md_ovf = 0; md_ferr = 0; md_done = 0;
         md_c1p = 0; md_c2p = 0;
      end else begin
         w = md_oct ? IMG_W / 2 : IMG_W;
         h = md_oct ? IMG_H / 2 : IMG_H;
         was_empty = (md_q.size() == 0);
         pop = !was_empty && m_ready;
         c1r = complete1 && !md_c1p;
         c2r = complete2 && !md_c2p;
         if (pop) e = md_q.pop_front();
         if (kp_en) begin
            if (md_phase < 2 && md_n < w * h) begin
               if (kp_flag) begin
                  e = {md_oct, CW'(md_n / w), CW'(md_n % w), kp_max, kp_min};
                  if (md_q.size() < DEPTH) begin
                     md_q.push_back(e);
                     if (md_kcnt < 65535) md_kcnt++;
                  end else begin
                     md_ovf = 1;
                     if (md_dcnt < 65535) md_dcnt++;
                  end
               end
               md_n++;
            end else begin
               md_ferr = 1;
            end
         end
         case (md_phase)
            0: begin
               if (c2r) begin md_phase = 2; md_oct = 1; end
               else if (c1r) begin md_phase = 1; md_oct = 1; md_n = 0; end
            end
            1: if (c2r) md_phase = 2;
            2: if (was_empty) md_phase = 3;
            default: md_phase = 3;
         endcase
         md_c1p = complete1;
         md_c2p = complete2;
         md_done = (md_phase == 3);
      end
   endtask

   // One clock: model update, edge, then compare every output to the model.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("m_valid", m_valid, (md_q.size() != 0));
      if (md_q.size() != 0) chk("m_data", m_data, md_q[0]);
      chk("octave", octave, md_oct);
      chk("kp_count", kp_count, md_kcnt);
      chk("drop_cnt", drop_cnt, md_dcnt);
      chk("overflow", overflow, md_ovf);
      chk("frame_err", frame_err, md_ferr);
      chk("done", done, md_done);
   endtask

   task automatic do_reset();
      rst = 1; kp_en = 0; kp_flag = 0; complete1 = 0; complete2 = 0; m_ready = 0;
      tick();
      rst = 0;
   endtask

   task automatic strobe(input bit f);
      kp_en = 1; kp_flag = f;
      kp_max = 8'($urandom); kp_min = 8'($urandom);
      tick();
      kp_en = 0; kp_flag = 0;
   endtask

   typedef struct {
      logic          en;
      logic          flag;
      logic [7:0]    mx;
      logic [7:0]    mn;
      logic          rdy;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic [15:0]   exp_kcnt;
   } vec_t;

   vec_t vt[6];
   logic [DW-1:0] d0;

   initial begin
      rst = 1; kp_en = 0; kp_flag = 0; kp_max = 0; kp_min = 0;
      complete1 = 0; complete2 = 0; m_ready = 0;

      // Reset state
      do_reset();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_kp_count", kp_count, 0);
      chk("rst_octave", octave, 0);
      chk("rst_done", done, 0);
      chk("rst_m_data", m_data, 0);

      // Table: keypoint on the 4th strobe, then pop
      d0 = {1'b0, 3'd0, 3'd3, 8'h28, 8'hFD};
      vt[0] = '{1, 0, 8'h00, 8'h00, 0, 0, '0, 16'd0};
      vt[1] = '{1, 0, 8'h00, 8'h00, 0, 0, '0, 16'd0};
      vt[2] = '{1, 0, 8'h00, 8'h00, 0, 0, '0, 16'd0};
      vt[3] = '{1, 1, 8'h28, 8'hFD, 0, 1, d0, 16'd1};
      vt[4] = '{1, 0, 8'h00, 8'h00, 0, 1, d0, 16'd1};
      vt[5] = '{0, 0, 8'h00, 8'h00, 1, 0, '0, 16'd1};
      for (int i = 0; i < 6; i++) begin
         kp_en = vt[i].en; kp_flag = vt[i].flag;
         kp_max = vt[i].mx; kp_min = vt[i].mn; m_ready = vt[i].rdy;
         tick();
         chk($sformatf("tbl%0d_valid", i), m_valid, vt[i].exp_valid);
         if (vt[i].exp_valid) chk($sformatf("tbl%0d_data", i), m_data, vt[i].exp_data);
         chk($sformatf("tbl%0d_kcnt", i), kp_count, vt[i].exp_kcnt);
      end
      kp_en = 0; m_ready = 0;

      // Row wrap, last position, overrun
      do_reset();
      m_ready = 1;
      for (int i = 0; i < 8; i++) strobe(0);
      strobe(1);
      chk("wrap_pos", m_data[DW-1:16], {1'b0, 3'd1, 3'd0});
      for (int i = 0; i < 54; i++) strobe(0);
      strobe(1);
      chk("last_pos", m_data[DW-1:16], {1'b0, 3'd7, 3'd7});
      chk("last_kcnt", kp_count, 2);
      strobe(1);
      chk("overrun_ferr", frame_err, 1);
      chk("overrun_kcnt", kp_count, 2);
      chk("overrun_valid", m_valid, 0);

      // Octave 1 addressing
      do_reset();
      complete1 = 1;
      tick();
      chk("oct1_octave", octave, 1);
      strobe(0);
      strobe(1);
      chk("oct1_pos1", m_data[DW-1:16], {1'b1, 3'd0, 3'd1});
      strobe(0); strobe(0); strobe(1);
      m_ready = 1;
      tick();
      m_ready = 0;
      chk("oct1_wrap", m_data[DW-1:16], {1'b1, 3'd1, 3'd0});

      // Overflow, then push+pop while full
      do_reset();
      for (int i = 0; i < 6; i++) strobe(1);
      chk("ovf_kcnt", kp_count, 4);
      chk("ovf_drop", drop_cnt, 2);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head", m_data[18:16], 0);
      m_ready = 1;
      strobe(1);
      chk("pp_drop", drop_cnt, 2);
      chk("pp_kcnt", kp_count, 5);
      chk("pp_head", m_data[18:16], 1);
      tick(); chk("pp_head2", m_data[18:16], 2);
      tick(); chk("pp_head3", m_data[18:16], 3);
      tick(); chk("pp_head4", m_data[18:16], 6);
      tick(); chk("pp_empty", m_valid, 0);
      m_ready = 0;

      // Reset mid-stream
      do_reset();
      strobe(1); strobe(1); strobe(1);
      chk("mid_valid", m_valid, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_kcnt", kp_count, 0);
      chk("mid_rst_oct", octave, 0);
      strobe(1);
      chk("mid_restart_col", m_data[DW-1:16], {1'b0, 3'd0, 3'd0});

      // Drain to done
      do_reset();
      strobe(1); strobe(1);
      complete1 = 1; tick();
      complete2 = 1; tick();
      chk("drn_oct", octave, 1);
      m_ready = 1;
      tick();
      tick();
      chk("drn_empty", m_valid, 0);
      chk("drn_notdone", done, 0);
      tick();
      chk("drn_done", done, 1);
      strobe(0);
      chk("drn_ferr", frame_err, 1);
      chk("drn_done_hold", done, 1);

      // Randomized episodes against the model
      for (int ep = 0; ep < 8; ep++) begin
         int c1_at;
         int c2_at;
         int rdy_pct;
         do_reset();
         c1_at = 40 + int'($urandom_range(0, 120));
         c2_at = c1_at + 20 + int'($urandom_range(0, 80));
         if (ep == 3) c1_at = 1000;
         rdy_pct = int'($urandom_range(10, 90));
         for (int c = 0; c < 300; c++) begin
            kp_en     = ($urandom_range(0, 3) != 0);
            kp_flag   = ($urandom_range(0, 2) == 0);
            kp_max    = 8'($urandom);
            kp_min    = 8'($urandom);
            m_ready   = (int'($urandom_range(0, 99)) < rdy_pct);
            complete1 = (c >= c1_at);
            complete2 = (c >= c2_at);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
            rst = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
